// File: rtl/hs_status_sampler.sv
// Samples one HLS block handshake, timestamps transactions and buffers
// fixed-format DONE/READY/FINISH records in a first-word-fall-through FIFO.
module hs_status_sampler #(
  parameter int CNT_W      = 32,
  parameter int DEPTH      = 16,
  parameter int READY_ONLY = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [1:0]       rec_kind,
  output logic [CNT_W-1:0] rec_stamp,
  output logic [CNT_W-1:0] rec_lat,
  output logic [CNT_W-1:0] rec_aux,
  output logic             busy,
  output logic             overflow,
  output logic             ended
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [AW:0]      LIM  = (AW+1)'(DEPTH - 1);
  localparam logic [1:0] K_READY = 2'd0, K_DONE = 2'd1, K_FIN = 2'd3;

  typedef struct packed {
    logic [1:0]       kind;
    logic [CNT_W-1:0] stamp;
    logic [CNT_W-1:0] lat;
    logic [CNT_W-1:0] aux;
  } rec_t;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, END} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cyc, t_start, t_start_nxt, t_done, t_done_nxt, stall, stall_nxt;
  logic [CNT_W-1:0] prev_ready, ev_count, drop_count;
  logic             seen_ready, fin_pend, fin_pend_nxt;
  logic             ev, fin_wr, push, pop, drop;
  rec_t             ev_rec, wr_data, head;
  rec_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, occ_after;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // An event coinciding with the first finish is recorded first; FINISH follows
  // one cycle later via fin_pend so the FIFO still sees a single write per cycle.
  always_comb begin
    state_nxt    = state;
    t_start_nxt  = t_start;
    t_done_nxt   = t_done;
    stall_nxt    = stall;
    fin_pend_nxt = 1'b0;
    ev           = 1'b0;
    fin_wr       = 1'b0;
    ev_rec       = '0;
    if (fin_pend) begin
      fin_wr    = 1'b1;
      state_nxt = END;
    end else if (state != END) begin
      if (READY_ONLY != 0) begin
        if (ap_ready) begin
          ev           = 1'b1;
          ev_rec.kind  = K_READY;
          ev_rec.stamp = cyc;
          ev_rec.lat   = seen_ready ? cyc - prev_ready : '0;
        end
      end else begin
        case (state)
          IDLE: if (ap_start) begin
            t_start_nxt = cyc;
            state_nxt   = RUN;
          end
          RUN: if (ap_done) begin
            if (ap_continue) begin
              ev           = 1'b1;
              ev_rec.kind  = K_DONE;
              ev_rec.stamp = cyc;
              ev_rec.lat   = cyc - t_start;
              if (ap_start) t_start_nxt = cyc + 1'b1;
              else          state_nxt   = IDLE;
            end else begin
              t_done_nxt = cyc;
              stall_nxt  = '0;
              state_nxt  = HOLD;
            end
          end
          HOLD: if (ap_continue) begin
            ev           = 1'b1;
            ev_rec.kind  = K_DONE;
            ev_rec.stamp = t_done;
            ev_rec.lat   = t_done - t_start;
            ev_rec.aux   = stall + 1'b1;
            state_nxt    = IDLE;
          end else if (stall != CMAX) begin
            stall_nxt = stall + 1'b1;
          end
          default: ;
        endcase
      end
      if (finish) begin
        if (ev) begin
          fin_pend_nxt = 1'b1;
          state_nxt    = IDLE;
        end else begin
          fin_wr    = 1'b1;
          state_nxt = END;
        end
      end
    end
  end

  // Keep one slot free so FINISH can always be written.
  always_comb begin
    pop       = rec_valid & rec_ready;
    occ_after = count - {{AW{1'b0}}, pop};
    drop      = ev && (occ_after >= LIM);
    push      = (ev && !drop) || fin_wr;
    if (fin_wr) begin
      wr_data.kind  = K_FIN;
      wr_data.stamp = cyc;
      wr_data.lat   = ev_count;
      wr_data.aux   = drop_count;
    end else begin
      wr_data = ev_rec;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc        <= '0;
      t_start    <= '0;
      t_done     <= '0;
      stall      <= '0;
      prev_ready <= '0;
      seen_ready <= 1'b0;
      fin_pend   <= 1'b0;
      ev_count   <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (cyc != CMAX) cyc <= cyc + 1'b1;
      t_start  <= t_start_nxt;
      t_done   <= t_done_nxt;
      stall    <= stall_nxt;
      fin_pend <= fin_pend_nxt;
      if (ev && ev_count != CMAX) ev_count <= ev_count + 1'b1;
      if (ev && READY_ONLY != 0) begin
        prev_ready <= cyc;
        seen_ready <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != CMAX) drop_count <= drop_count + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign head      = mem[rd_ptr];
  assign rec_valid = (count != '0);
  assign rec_kind  = rec_valid ? head.kind  : '0;
  assign rec_stamp = rec_valid ? head.stamp : '0;
  assign rec_lat   = rec_valid ? head.lat   : '0;
  assign rec_aux   = rec_valid ? head.aux   : '0;
  assign busy      = (state == RUN) || (state == HOLD);
  assign ended     = (state == END);
endmodule

// File: tb/tb_hs_status_sampler.sv
// Scoreboard bench: directed handshake vectors push expected records; a
// per-instance monitor pops and compares on every accepted record.
module tb_hs_status_sampler;
  localparam int W = 32;

  typedef struct {
    longint kind, stamp, lat, aux, at;
  } exp_t;

  logic clock = 1'b0, reset = 1'b0;
  always #5 clock = ~clock;

  logic start0, ready0, done0, cont0, fin0, rr0;
  logic v0, busy0, ovf0, end0;
  logic [1:0] kind0;
  logic [W-1:0] stamp0, lat0, aux0;

  logic start1, ready1, done1, cont1, fin1, rr1;
  logic v1, busy1, ovf1, end1;
  logic [1:0] kind1;
  logic [W-1:0] stamp1, lat1, aux1;

  hs_status_sampler #(.CNT_W(W), .DEPTH(4), .READY_ONLY(0)) d0 (
    .clock(clock), .reset(reset), .ap_start(start0), .ap_ready(ready0),
    .ap_done(done0), .ap_continue(cont0), .finish(fin0), .rec_valid(v0),
    .rec_ready(rr0), .rec_kind(kind0), .rec_stamp(stamp0), .rec_lat(lat0),
    .rec_aux(aux0), .busy(busy0), .overflow(ovf0), .ended(end0));

  hs_status_sampler #(.CNT_W(W), .DEPTH(4), .READY_ONLY(1)) d1 (
    .clock(clock), .reset(reset), .ap_start(start1), .ap_ready(ready1),
    .ap_done(done1), .ap_continue(cont1), .finish(fin1), .rec_valid(v1),
    .rec_ready(rr1), .rec_kind(kind1), .rec_stamp(stamp1), .rec_lat(lat1),
    .rec_aux(aux1), .busy(busy1), .overflow(ovf1), .ended(end1));

  int   checks = 0, errors = 0, cyc_tb = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tb cycle %0d)", nm, got, exp, cyc_tb);
    end
  endtask

  always @(negedge clock) begin
    if (reset && v0 && rr0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL d0 unexpected record: got kind=%0d stamp=%0d expected none", kind0, stamp0);
      end else begin
        e0 = q0.pop_front();
        chk("d0 kind", kind0, e0.kind);
        chk("d0 stamp", stamp0, e0.stamp);
        chk("d0 lat", lat0, e0.lat);
        chk("d0 aux", aux0, e0.aux);
        if (e0.at >= 0) chk("d0 valid cycle", cyc_tb, e0.at);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && v1 && rr1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1 unexpected record: got kind=%0d stamp=%0d expected none", kind1, stamp1);
      end else begin
        e1 = q1.pop_front();
        chk("d1 kind", kind1, e1.kind);
        chk("d1 stamp", stamp1, e1.stamp);
        chk("d1 lat", lat1, e1.lat);
        chk("d1 aux", aux1, e1.aux);
        if (e1.at >= 0) chk("d1 valid cycle", cyc_tb, e1.at);
      end
    end
  end

  task automatic idle_inputs();
    {start0, ready0, done0, fin0} = '0; cont0 = 1'b1; rr0 = 1'b1;
    {start1, ready1, done1, fin1, cont1} = '0; rr1 = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset  = 1'b1;
    cyc_tb = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc_tb++;
  endtask

  task automatic drained(input string nm);
    chk({nm, " d0 queue left"}, q0.size(), 0);
    chk({nm, " d1 queue left"}, q1.size(), 0);
  endtask

  initial begin
    idle_inputs();
    #3;
    chk("reset rec_valid", v0, 0);
    chk("reset busy", busy0, 0);
    chk("reset overflow", ovf0, 0);
    chk("reset ended", end0, 0);
    chk("reset rec_stamp", stamp0, 0);

    // normal DONE
    do_reset();
    q0.push_back('{1, 12, 7, 0, 13});
    for (int c = 0; c <= 15; c++) begin
      start0 = (c == 5); done0 = (c == 12);
      if (c <= 14) chk("busy normal", busy0, (c >= 6 && c <= 12));
      tick();
    end
    drained("normal");

    // continue stall
    do_reset();
    q0.push_back('{1, 10, 7, 4, 15});
    for (int c = 0; c <= 17; c++) begin
      start0 = (c == 3); done0 = (c == 10); cont0 = !(c >= 10 && c <= 13);
      if (c == 12) chk("busy in hold", busy0, 1);
      if (c == 16) chk("busy after hold", busy0, 0);
      tick();
    end
    drained("stall");

    // back-to-back, then finish abandons an open RUN
    do_reset();
    q0.push_back('{1, 8, 8, 0, 9});
    q0.push_back('{1, 15, 6, 0, 16});
    q0.push_back('{3, 18, 2, 0, 19});
    for (int c = 0; c <= 24; c++) begin
      start0 = (c <= 16) || (c >= 20 && c % 2 == 0);
      done0  = (c == 8) || (c == 15) || (c >= 20);
      fin0   = (c >= 18);
      if (c == 17) chk("busy b2b", busy0, 1);
      if (c == 18) chk("ended before finish", end0, 0);
      if (c == 19) begin chk("ended after finish", end0, 1); chk("busy after finish", busy0, 0); end
      if (c == 24) chk("ended stays", end0, 1);
      tick();
    end
    drained("b2b");

    // DONE and finish in the same cycle
    do_reset();
    q0.push_back('{1, 4, 3, 0, 5});
    q0.push_back('{3, 5, 1, 0, 6});
    for (int c = 0; c <= 8; c++) begin
      start0 = (c == 1); done0 = (c == 4); fin0 = (c >= 4);
      if (c == 5) begin chk("ended pending", end0, 0); chk("busy pending", busy0, 0); end
      if (c == 6) chk("ended same-cycle", end0, 1);
      tick();
    end
    drained("same-cycle");

    // overflow with DEPTH=4
    do_reset();
    q0.push_back('{1, 2, 2, 0, 14});
    q0.push_back('{1, 4, 1, 0, 15});
    q0.push_back('{1, 6, 1, 0, 16});
    q0.push_back('{3, 12, 5, 2, 17});
    for (int c = 0; c <= 18; c++) begin
      start0 = (c <= 9);
      done0  = (c == 2) || (c == 4) || (c == 6) || (c == 8) || (c == 10);
      fin0   = (c >= 12);
      rr0    = (c >= 14);
      if (c == 8) chk("overflow before drop", ovf0, 0);
      if (c == 9) chk("overflow after drop", ovf0, 1);
      if (c == 13) begin chk("rec_valid full", v0, 1); chk("ended overflow", end0, 1); end
      if (c == 18) begin chk("overflow sticky", ovf0, 1); chk("rec_valid drained", v0, 0); end
      tick();
    end
    drained("overflow");

    // asynchronous reset with records buffered and a RUN open
    do_reset();
    rr0 = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      start0 = 1'b1; done0 = (c == 2) || (c == 4) || (c == 6) || (c == 8);
      tick();
    end
    chk("pre-reset overflow", ovf0, 1);
    chk("pre-reset rec_valid", v0, 1);
    chk("pre-reset busy", busy0, 1);
    #2 reset = 1'b0;
    #1;
    chk("async rec_valid", v0, 0);
    chk("async busy", busy0, 0);
    chk("async overflow", ovf0, 0);
    chk("async rec_kind", kind0, 0);
    @(posedge clock);
    @(negedge clock);
    idle_inputs();
    reset  = 1'b1;
    cyc_tb = 0;
    q0.push_back('{1, 3, 2, 0, 4});
    for (int c = 0; c <= 8; c++) begin
      start0 = (c == 1); done0 = (c == 3);
      tick();
    end
    drained("reset mid-run");

    // READY_ONLY instance
    do_reset();
    q1.push_back('{0, 2, 0, 0, 3});
    q1.push_back('{0, 6, 4, 0, 7});
    q1.push_back('{0, 7, 1, 0, 8});
    q1.push_back('{0, 10, 3, 0, 11});
    q1.push_back('{0, 11, 1, 0, 12});
    q1.push_back('{0, 12, 1, 0, 13});
    q1.push_back('{3, 14, 6, 0, 15});
    for (int c = 0; c <= 18; c++) begin
      ready1 = (c == 2) || (c == 6) || (c == 7) || (c >= 10 && c <= 12);
      start1 = (c % 2 == 1); done1 = (c % 2 == 0); cont1 = (c % 4 >= 2);
      fin1   = (c >= 14);
      if (c == 5) chk("ready-only busy", busy1, 0);
      if (c == 14) chk("ready-only ended before", end1, 0);
      if (c == 15) chk("ready-only ended", end1, 1);
      tick();
    end
    drained("ready-only");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
